// File: rtl/otter_fetch_unit.sv
// OTTER instruction fetch / PC update: single-outstanding imem request, IR hold
// toward decode, and a sticky trap on misaligned redirect targets.
module otter_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  PC_SEL,
  input  logic [31:0] JALR_TARGET,
  input  logic [31:0] BRANCH_TARGET,
  input  logic [31:0] JAL_TARGET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] IR,
  output logic [31:0] IR_PC,
  output logic        IR_VALID,
  input  logic        IR_READY,
  output logic        TRAP,
  output logic [31:0] TRAP_ADDR
);

  typedef enum logic [1:0] {FETCH, HOLD, ERROR} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, next_pc;
  logic        misaligned, accept, fill;

  always_comb begin
    next_pc = pc + 32'd4;
    case (PC_SEL)
      2'b01:   next_pc = JALR_TARGET & ~32'h1;
      2'b10:   next_pc = BRANCH_TARGET;
      2'b11:   next_pc = JAL_TARGET;
      default: next_pc = pc + 32'd4;
    endcase
  end

  assign misaligned = next_pc[1:0] != 2'b00;
  assign fill       = (state == FETCH) && IMEM_ACK;
  assign accept     = (state == HOLD) && IR_READY;

  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= FETCH;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (IMEM_ACK) state_nxt = HOLD;
      HOLD:    if (IR_READY) state_nxt = misaligned ? ERROR : FETCH;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc        <= RESET_VECTOR;
      IR        <= '0;
      IR_PC     <= '0;
      TRAP      <= 1'b0;
      TRAP_ADDR <= '0;
    end else begin
      if (fill) begin
        IR    <= IMEM_RDATA;
        IR_PC <= pc;
      end
      // a misaligned redirect freezes the PC and parks the unit in ERROR
      if (accept) begin
        if (misaligned) begin
          TRAP      <= 1'b1;
          TRAP_ADDR <= next_pc;
        end else begin
          pc <= next_pc;
        end
      end
    end
  end

  assign IMEM_REQ  = (state == FETCH);
  assign IMEM_ADDR = pc;
  assign IR_VALID  = (state == HOLD);

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Scoreboard bench: fetch addresses and IR contents are queued as stimulus is
// driven and compared when the fetch unit presents them.
module tb_otter_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  PC_SEL = 2'b00;
  logic [31:0] JALR_TARGET = '0, BRANCH_TARGET = '0, JAL_TARGET = '0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK = 1'b0;
  logic [31:0] IMEM_RDATA = '0;
  logic [31:0] IR, IR_PC;
  logic        IR_VALID;
  logic        IR_READY = 1'b0;
  logic        TRAP;
  logic [31:0] TRAP_ADDR;

  int n_chk = 0, n_pass = 0;
  logic [31:0] addr_q[$];
  logic [63:0] ir_q[$];
  logic        trapped;

  otter_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .PC_SEL(PC_SEL), .JALR_TARGET(JALR_TARGET),
    .BRANCH_TARGET(BRANCH_TARGET), .JAL_TARGET(JAL_TARGET),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK),
    .IMEM_RDATA(IMEM_RDATA), .IR(IR), .IR_PC(IR_PC), .IR_VALID(IR_VALID),
    .IR_READY(IR_READY), .TRAP(TRAP), .TRAP_ADDR(TRAP_ADDR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
  endtask

  // One full fetch/hold/accept round; all input changes happen on negedges.
  task automatic fetch(input int wait_n, input int hold_n, input logic [1:0] sel,
                       input logic [31:0] tgt, output logic trap_o);
    logic [31:0] a, nx, rd;
    logic [63:0] e;
    if (addr_q.size() == 0) begin
      chk("addr_q_empty", 32'd0, 32'd1);
      a = 32'hxxxx_xxxx;
    end else a = addr_q.pop_front();
    chk("req", {31'd0, IMEM_REQ}, 32'd1);
    chk("addr", IMEM_ADDR, a);
    chk("vld_fetch", {31'd0, IR_VALID}, 32'd0);
    for (int i = 0; i < wait_n; i++) begin
      @(negedge CLK);
      chk("addr_wait", IMEM_ADDR, a);
      chk("req_wait", {31'd0, IMEM_REQ}, 32'd1);
    end
    rd = a ^ 32'h5A5A_A5A5;
    IMEM_ACK = 1'b1; IMEM_RDATA = rd;
    ir_q.push_back({rd, a});
    @(negedge CLK);
    for (int i = 0; i < hold_n; i++) begin
      chk("vld_hold", {31'd0, IR_VALID}, 32'd1);
      chk("req_hold", {31'd0, IMEM_REQ}, 32'd0);
      // stray ACK in HOLD must not disturb IR
      IMEM_ACK = 1'b1; IMEM_RDATA = 32'hBAD0_0000 | i;
      @(negedge CLK);
    end
    IMEM_ACK = 1'b0;
    chk("vld", {31'd0, IR_VALID}, 32'd1);
    e = ir_q.pop_front();
    chk("ir", IR, e[63:32]);
    chk("ir_pc", IR_PC, e[31:0]);
    JALR_TARGET = 32'hDEAD_BE01; BRANCH_TARGET = 32'hDEAD_BE10; JAL_TARGET = 32'hDEAD_BE20;
    case (sel)
      2'b00: nx = a + 32'd4;
      2'b01: begin JALR_TARGET = tgt; nx = {tgt[31:1], 1'b0}; end
      2'b10: begin BRANCH_TARGET = tgt; nx = tgt; end
      default: begin JAL_TARGET = tgt; nx = tgt; end
    endcase
    PC_SEL = sel; IR_READY = 1'b1;
    trap_o = nx[1:0] != 2'b00;
    if (!trap_o) addr_q.push_back(nx);
    @(negedge CLK);
    IR_READY = 1'b0; PC_SEL = 2'b00;
    chk("vld_after_accept", {31'd0, IR_VALID}, 32'd0);
    chk("trap", {31'd0, TRAP}, {31'd0, trap_o});
    if (trap_o) chk("trap_addr", TRAP_ADDR, nx);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_req", {31'd0, IMEM_REQ}, 32'd1);
    chk("rst_addr", IMEM_ADDR, 32'h0);
    chk("rst_ir", IR, 32'h0);
    chk("rst_ir_pc", IR_PC, 32'h0);
    chk("rst_vld", {31'd0, IR_VALID}, 32'd0);
    chk("rst_trap", {31'd0, TRAP}, 32'd0);
    chk("rst_trap_addr", TRAP_ADDR, 32'h0);
    RST = 1'b0;
    addr_q.push_back(32'h0);

    fetch(0, 0, 2'b00, 32'h0, trapped);          // 0 -> 4
    fetch(0, 0, 2'b00, 32'h0, trapped);          // 4 -> 8
    fetch(0, 0, 2'b11, 32'h100, trapped);        // 8 -> 0x100
    fetch(0, 0, 2'b10, 32'h40, trapped);         // branch to 0x40
    fetch(0, 0, 2'b11, 32'h200, trapped);        // jal to 0x200
    fetch(0, 0, 2'b01, 32'h305, trapped);        // bit0 cleared -> 0x304, aligned
    fetch(0, 1, 2'b01, 32'h311, trapped);        // -> 0x310
    fetch(0, 0, 2'b11, 32'hFFFF_FFFC, trapped);
    fetch(0, 0, 2'b00, 32'h0, trapped);          // wraps to 0
    fetch(3, 2, 2'b00, 32'h0, trapped);          // waits; one advance to 4
    fetch(0, 0, 2'b11, 32'h20, trapped);         // -> 0x20

    // async reset while holding the instruction at 0x20
    void'(addr_q.pop_front());
    chk("addr_20", IMEM_ADDR, 32'h20);
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'h1234_5678;
    @(negedge CLK);
    IMEM_ACK = 1'b0;
    chk("hold_ir_pc_20", IR_PC, 32'h20);
    chk("hold_vld_20", {31'd0, IR_VALID}, 32'd1);
    #3 RST = 1'b1;
    #1;
    chk("async_vld", {31'd0, IR_VALID}, 32'd0);
    chk("async_trap", {31'd0, TRAP}, 32'd0);
    chk("async_ir_pc", IR_PC, 32'h0);
    chk("async_addr", IMEM_ADDR, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    addr_q.push_back(32'h0);
    fetch(0, 0, 2'b00, 32'h0, trapped);          // 0 -> 4
    fetch(1, 0, 2'b01, 32'h307, trapped);        // -> 0x306 misaligned
    chk("trap_expected", {31'd0, trapped}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      IMEM_ACK = 1'b1; IR_READY = 1'b1;
      @(negedge CLK);
      chk("err_req", {31'd0, IMEM_REQ}, 32'd0);
      chk("err_vld", {31'd0, IR_VALID}, 32'd0);
      chk("err_trap", {31'd0, TRAP}, 32'd1);
      chk("err_trap_addr", TRAP_ADDR, 32'h306);
      chk("err_pc_frozen", IMEM_ADDR, 32'h4);
    end
    IMEM_ACK = 1'b0; IR_READY = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("post_rst_trap", {31'd0, TRAP}, 32'd0);
    chk("post_rst_req", {31'd0, IMEM_REQ}, 32'd1);
    chk("post_rst_addr", IMEM_ADDR, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
